// File: rtl/matmul_mem_sequencer_if.sv
// Memory-port and control bundle between matmul_mem_sequencer and its environment.
// master: sequencer side (drives busy/done and the memory strobes, address, write data).
// slave : core/memory side (drives start and the combinational read data).
//   start     - one-cycle run request
//   busy      - sequencer owns the memory port
//   done      - one-cycle completion pulse
//   memread   - read strobe
//   memwrite  - write strobe
//   address   - byte address
//   mem_wdata - write data (memory data_in)
//   mem_rdata - read data (memory data_out), valid in the same cycle as address
interface matmul_mem_sequencer_if #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 32
);
  logic              start;
  logic              busy;
  logic              done;
  logic              memread;
  logic              memwrite;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  start, mem_rdata,
    output busy, done, memread, memwrite, address, mem_wdata
  );

  modport slave (
    output start, mem_rdata,
    input  busy, done, memread, memwrite, address, mem_wdata
  );
endinterface

// File: rtl/matmul_mem_sequencer.sv
// Sequences the data memory to compute C = A x B for NxN matrices of DATA_W-bit words.
// A is read from A_BASE, B from B_BASE, C is written to C_BASE (row-major, 4-byte stride).
// Per C element: N x (RD_A, RD_B) multiply-accumulate pairs followed by one WR.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset, priority over everything
//   bus   - matmul_mem_sequencer_if.master (start/busy/done + memory port)
// All bus outputs are registered; they are loaded with the decode of the state being
// entered so that address/strobes line up with the cycle the state is active.
module matmul_mem_sequencer #(
  parameter int unsigned       N      = 3,
  parameter int unsigned       ADDR_W = 17,
  parameter int unsigned       DATA_W = 32,
  parameter logic [ADDR_W-1:0] A_BASE = 17'h00200,
  parameter logic [ADDR_W-1:0] B_BASE = 17'h00300,
  parameter logic [ADDR_W-1:0] C_BASE = 17'h00100
) (
  input  logic                    clk,
  input  logic                    reset,
  matmul_mem_sequencer_if.master  bus
);

  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    WR,
    DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  i;
  logic [CNT_W-1:0]  j;
  logic [CNT_W-1:0]  k;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_sum;

  // Byte address of element (row, col) of an NxN row-major matrix at base.
  function automatic logic [ADDR_W-1:0] elem_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [CNT_W-1:0]  row,
                                                  input logic [CNT_W-1:0]  col);
    return base + ADDR_W'((N * 32'(row) + 32'(col)) * 32'd4);
  endfunction

  // Multiply-accumulate; keeps the low DATA_W bits (modulo wrap).
  assign acc_sum = acc + a_reg * bus.mem_rdata;

  // FSM, counters, datapath and registered memory-port outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      i             <= '0;
      j             <= '0;
      k             <= '0;
      a_reg         <= '0;
      acc           <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.memread   <= 1'b0;
      bus.memwrite  <= 1'b0;
      bus.address   <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.done      <= 1'b0;
      bus.memread   <= 1'b0;
      bus.memwrite  <= 1'b0;
      bus.address   <= '0;
      bus.mem_wdata <= '0;

      case (state)
        IDLE: begin
          if (bus.start) begin
            state       <= RD_A;
            i           <= '0;
            j           <= '0;
            k           <= '0;
            acc         <= '0;
            bus.busy    <= 1'b1;
            bus.memread <= 1'b1;
            bus.address <= elem_addr(A_BASE, '0, '0);
          end
        end

        RD_A: begin
          a_reg       <= bus.mem_rdata;
          state       <= RD_B;
          bus.memread <= 1'b1;
          bus.address <= elem_addr(B_BASE, k, j);
        end

        RD_B: begin
          acc <= acc_sum;
          if (k != LAST) begin
            k           <= k + CNT_W'(1);
            state       <= RD_A;
            bus.memread <= 1'b1;
            bus.address <= elem_addr(A_BASE, i, k + CNT_W'(1));
          end else begin
            // Write data is the fully accumulated sum, taken straight from the adder.
            k             <= '0;
            state         <= WR;
            bus.memwrite  <= 1'b1;
            bus.address   <= elem_addr(C_BASE, i, j);
            bus.mem_wdata <= acc_sum;
          end
        end

        WR: begin
          acc <= '0;
          if (i == LAST && j == LAST) begin
            j        <= '0;
            state    <= DONE;
            bus.done <= 1'b1;
          end else if (j != LAST) begin
            j           <= j + CNT_W'(1);
            state       <= RD_A;
            bus.memread <= 1'b1;
            bus.address <= elem_addr(A_BASE, i, '0);
          end else begin
            j           <= '0;
            i           <= i + CNT_W'(1);
            state       <= RD_A;
            bus.memread <= 1'b1;
            bus.address <= elem_addr(A_BASE, i + CNT_W'(1), '0);
          end
        end

        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/matmul_mem_sequencer.md
Name: matmul_mem_sequencer

Overview:
- Controller that sequences the main data memory to compute C = A x B for 3x3 matrices of 32-bit words.
- A is read from the matrix1 region, B from the matrix2 region, and C is written to the matrix3 region.
- It is the sole master of the memory port (memread, memwrite, address, write data) while busy; the core hands the port over for the duration of a run.
- A single-cycle start launches a run; a single-cycle done reports completion.

Parameters:
- N, 3, matrix dimension; loop counters i, j, k range 0..N-1.
- ADDR_W, 17, memory address width.
- DATA_W, 32, data word width.
- A_BASE, 17'h00200, byte base address of A (row-major, 4-byte stride).
- B_BASE, 17'h00300, byte base address of B.
- C_BASE, 17'h00100, byte base address of C.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a run; sampled only in IDLE.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse in the DONE state.
- memread  output  1  memory read strobe.
- memwrite  output  1  memory write strobe.
- address  output  ADDR_W  memory byte address.
- mem_wdata  output  DATA_W  write data, connected to the memory data_in.
- mem_rdata  input  DATA_W  read data from the memory data_out; combinational, valid in the same cycle as address/memread.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; i, j, k, a_reg and acc cleared to 0; busy, done, memread, memwrite=0; address and mem_wdata=0. Reset has priority over every other condition, including mid-run: the next edge returns the block to IDLE. Any C words already written stay in memory.
- Memory port outputs are decoded from state and counters. memread and memwrite are never high together. In IDLE and DONE, address and mem_wdata are 0.
- IDLE: when start=1, go to RD_A with i=j=k=0 and acc=0. Otherwise stay.
- RD_A:
  - memread=1; address = A_BASE + 4*(N*i+k).
  - At the edge, a_reg <= mem_rdata. Go to RD_B.
- RD_B:
  - memread=1; address = B_BASE + 4*(N*k+j).
  - At the edge, acc <= acc + a_reg*mem_rdata, keeping the low 32 bits (unsigned modulo 2^32 wrap, no saturation, no overflow flag).
  - If k<N-1: k++ and go to RD_A. Otherwise k=0 and go to WR.
- WR:
  - memwrite=1; address = C_BASE + 4*(N*i+j); mem_wdata = acc.
  - At the edge, acc <= 0.
  - If j<N-1: j++. Else j=0 and, if i<N-1, i++. Either way go to RD_A.
  - If i=j=N-1: go to DONE instead.
- DONE: done=1 for exactly one cycle; next state IDLE unconditionally.
- Latency: start is sampled at edge 0. RD_A is active in cycle 1. Each C element takes 2N+1 = 7 cycles. The last WR is in cycle 63, DONE in cycle 64, and IDLE from cycle 65. busy is high in cycles 1..64.
- C write order is row-major: 0x100, 0x104, ..., 0x120.
- start while busy (any non-IDLE state) is ignored, with no queuing. start high in the same cycle as reset is ignored.
- start held high continuously re-launches a run on the first IDLE cycle after DONE.
- The block does not check memory contents or address validity.

Test Plan:
- Address sequence: after a start pulse, cycles 1..7 show (rd,0x200), (rd,0x300), (rd,0x204), (rd,0x30C), (rd,0x208), (rd,0x318), (wr,0x100). busy rises in cycle 1, done pulses in cycle 64 only, busy falls in cycle 65.
- Identity: A=1..9, B=identity -> matrix3 = 1,2,3,4,5,6,7,8,9 after done.
- Product: A=1..9, B=1..9 -> matrix3 = 30,36,42,66,81,96,102,126,150.
- Wrap: A[0]=32'h80000000, B[0]=2, all other A/B words 0 -> C[0]=0, all nine C words 0, no error indication.
- Start while busy: extra start pulses in cycles 10 and 40 -> timing unchanged, exactly one done in cycle 64, no second run.
- Reset mid-run: assert reset in cycle 20 -> next cycle all outputs 0 and busy=0. A fresh start then yields the full, correct product with the same 64-cycle timing.
